// File: rtl/screen_pkg.sv
// Shared constants and state encoding for the screen scan responder.
package screen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    localparam int SCREEN_SIZE_X_DEF = 160;
    localparam int SCREEN_SIZE_Y_DEF = 120;
    localparam int ADDR_WIDTH_DEF    = 15;

endpackage

// File: rtl/screen_addr_calc.sv
// Framebuffer address y*SCREEN_SIZE_X + x, registered: 1-cycle latency.
// No handshake; the address follows its inputs every cycle.
module screen_addr_calc
    import screen_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int SCREEN_SIZE_X = SCREEN_SIZE_X_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      x,
    input  logic [WIDTH-1:0]      y,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_SIZE_X);

    logic [ADDR_WIDTH-1:0] addr_d;

    // Off-screen coordinates may alias here; the caller never writes those.
    assign addr_d = ADDR_WIDTH'(y) * ROW_STRIDE + ADDR_WIDTH'(x);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr <= '0;
        end else begin
            addr <= addr_d;
        end
    end

endmodule

// File: rtl/screen_scan.sv
// Raster-walks a latched rectangle doing read-modify-write per pixel: 2 cycles/pixel, done 2*N+2 after start.
// No backpressure; start is only sampled in IDLE. Build option SCREEN_SKIP_UNCHANGED_EN drops same-colour writes.
module screen_scan
    import screen_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int COLOUR_WIDTH  = 3,
    parameter int SCREEN_SIZE_X = SCREEN_SIZE_X_DEF,
    parameter int SCREEN_SIZE_Y = SCREEN_SIZE_Y_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    screen_start,
    input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
    input  logic [WIDTH-1:0]        screen_x_min,
    input  logic [WIDTH-1:0]        screen_y_min,
    input  logic [WIDTH-1:0]        screen_x_range,
    input  logic [WIDTH-1:0]        screen_y_range,
    output logic [WIDTH-1:0]        screen_x,
    output logic [WIDTH-1:0]        screen_y,
    output logic [COLOUR_WIDTH-1:0] old_screen_colour,
    output logic                    screen_done,
    output logic [ADDR_WIDTH-1:0]   fb_addr,
    input  logic [COLOUR_WIDTH-1:0] fb_rdata,
    output logic [COLOUR_WIDTH-1:0] fb_wdata,
    output logic                    fb_we
);

    localparam logic [WIDTH:0] X_LIMIT = (WIDTH+1)'(SCREEN_SIZE_X);
    localparam logic [WIDTH:0] Y_LIMIT = (WIDTH+1)'(SCREEN_SIZE_Y);

    scan_state_t    state, state_nxt;

    // One extra bit so a rectangle reaching past 2^WIDTH-1 still terminates.
    logic [WIDTH:0] cur_x, cur_y;
    logic [WIDTH:0] cur_x_nxt, cur_y_nxt;
    logic [WIDTH:0] x_end, y_end;
    logic [WIDTH-1:0] x_min_q;
    logic           load;
    logic           clipped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_x_nxt = cur_x;
        cur_y_nxt = cur_y;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (screen_start) begin
                    load      = 1'b1;
                    cur_x_nxt = {1'b0, screen_x_min};
                    cur_y_nxt = {1'b0, screen_y_min};
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (cur_x < x_end) begin
                    cur_x_nxt = cur_x + 1'b1;
                    state_nxt = ST_READ;
                end else if (cur_y < y_end) begin
                    cur_x_nxt = {1'b0, x_min_q};
                    cur_y_nxt = cur_y + 1'b1;
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_x       <= '0;
            cur_y       <= '0;
            x_min_q     <= '0;
            x_end       <= '0;
            y_end       <= '0;
            screen_done <= 1'b0;
        end else begin
            cur_x       <= cur_x_nxt;
            cur_y       <= cur_y_nxt;
            screen_done <= (state == ST_DONE);
            if (load) begin
                x_min_q <= screen_x_min;
                x_end   <= {1'b0, screen_x_min} + {1'b0, screen_x_range};
                y_end   <= {1'b0, screen_y_min} + {1'b0, screen_y_range};
            end
        end
    end

    // Address is computed from the next coordinates so it is already valid in READ.
    screen_addr_calc #(
        .WIDTH         (WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .SCREEN_SIZE_X (SCREEN_SIZE_X)
    ) u_addr_calc (
        .clock (clock),
        .reset (reset),
        .x     (cur_x_nxt[WIDTH-1:0]),
        .y     (cur_y_nxt[WIDTH-1:0]),
        .addr  (fb_addr)
    );

    assign clipped           = (cur_x >= X_LIMIT) || (cur_y >= Y_LIMIT);
    assign screen_x          = cur_x[WIDTH-1:0];
    assign screen_y          = cur_y[WIDTH-1:0];
    assign old_screen_colour = fb_rdata;
    assign fb_wdata          = (state == ST_WRITE) ? new_screen_colour : '0;

`ifdef SCREEN_SKIP_UNCHANGED_EN
    assign fb_we = (state == ST_WRITE) && !clipped && (new_screen_colour != fb_rdata);
`else
    assign fb_we = (state == ST_WRITE) && !clipped;
`endif

endmodule

// File: tb/tb_screen_scan.sv
// Directed bench for screen_scan with a behavioural framebuffer and draw engine.
module tb_screen_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        screen_start;
    logic [2:0]  new_screen_colour;
    logic [7:0]  screen_x_min, screen_y_min, screen_x_range, screen_y_range;
    logic [7:0]  screen_x, screen_y;
    logic [2:0]  old_screen_colour;
    logic        screen_done;
    logic [14:0] fb_addr;
    logic [2:0]  fb_rdata;
    logic [2:0]  fb_wdata;
    logic        fb_we;

    logic [2:0]  mem [0:32767];
    logic        init_req;
    logic        pre_we;
    logic [14:0] pre_addr;
    logic [2:0]  pre_dat;
    logic        eng_mode;
    logic [2:0]  eng_col;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          wr_addr[$];
    int          wr_data[$];

    screen_scan dut (
        .clock             (clock),
        .reset             (reset),
        .screen_start      (screen_start),
        .new_screen_colour (new_screen_colour),
        .screen_x_min      (screen_x_min),
        .screen_y_min      (screen_y_min),
        .screen_x_range    (screen_x_range),
        .screen_y_range    (screen_y_range),
        .screen_x          (screen_x),
        .screen_y          (screen_y),
        .old_screen_colour (old_screen_colour),
        .screen_done       (screen_done),
        .fb_addr           (fb_addr),
        .fb_rdata          (fb_rdata),
        .fb_wdata          (fb_wdata),
        .fb_we             (fb_we)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Engine: either a flat colour, or echo the old colour on odd columns.
    assign new_screen_colour = (eng_mode && screen_x[0]) ? old_screen_colour : eng_col;

    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < 32768; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (fb_we) begin
            mem[fb_addr] <= fb_wdata;
        end
        fb_rdata <= mem[fb_addr];
    end

    always @(negedge clock) begin
        if (!reset && fb_we) begin
            wr_addr.push_back(32'(fb_addr));
            wr_data.push_back(32'(fb_wdata));
        end
        if (screen_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_rect(input int xm, input int ym, input int xr, input int yr, output int a0);
        @(negedge clock);
        screen_x_min   = 8'(xm);
        screen_y_min   = 8'(ym);
        screen_x_range = 8'(xr);
        screen_y_range = 8'(yr);
        screen_start   = 1'b1;
        a0             = cyc;
        @(negedge clock);
        screen_start   = 1'b0;
    endtask

    task automatic wait_done(input int a0, input int budget, output int lat);
        lat = -1;
        while (cyc - a0 < budget) begin
            if (screen_done) begin
                lat = cyc - a0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic preload(input int addr, input int dat);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = 15'(addr);
        pre_dat  = 3'(dat);
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    initial begin
        int a0, lat, b, d0, n;
        int exp1[4];
        int exp4a[4];
        int exp4d[4];
        exp1  = '{482, 483, 642, 643};
        exp4a = '{810, 811, 812, 813};
        exp4d = '{2, 7, 2, 7};

        reset = 1'b1;
        screen_start = 1'b0;
        screen_x_min = '0;
        screen_y_min = '0;
        screen_x_range = '0;
        screen_y_range = '0;
        eng_mode = 1'b0;
        eng_col = '0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_dat = '0;
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
        @(negedge clock);
        check("rst_x", 32'(screen_x), 32'd0);
        check("rst_y", 32'(screen_y), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_wdata", 32'(fb_wdata), 32'd0);
        check("rst_done", 32'(screen_done), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 2x2 rectangle at (2,3)
        eng_col = 3'd5;
        b = wr_addr.size();
        d0 = done_cnt;
        start_rect(2, 3, 1, 1, a0);
        check("t1_read_x", 32'(screen_x), 32'd2);
        check("t1_read_y", 32'(screen_y), 32'd3);
        check("t1_read_addr", 32'(fb_addr), 32'd482);
        wait_done(a0, 60, lat);
        check("t1_latency", lat, 10);
        @(negedge clock);
        check("t1_done_width", 32'(screen_done), 32'd0);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_writes", wr_addr.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_wr_addr", wr_addr[b+i], exp1[i]);
            check("t1_wr_data", wr_data[b+i], 5);
        end
        check("t1_mem643", 32'(mem[643]), 32'd5);

        // full-screen clear
        eng_col = 3'd0;
        b = wr_addr.size();
        start_rect(0, 0, 159, 119, a0);
        wait_done(a0, 40000, lat);
        check("t2_latency", lat, 38402);
        n = wr_addr.size() - b;
        check("t2_writes", n, 19200);
        check("t2_last_addr", wr_addr[wr_addr.size()-1], 19199);
        check("t2_mem482", 32'(mem[482]), 32'd0);

        // right-edge clipping
        preload(160, 3);
        eng_col = 3'd6;
        b = wr_addr.size();
        start_rect(158, 0, 3, 0, a0);
        wait_done(a0, 60, lat);
        check("t3_latency", lat, 10);
        check("t3_writes", wr_addr.size() - b, 2);
        check("t3_wr0", wr_addr[b], 158);
        check("t3_wr1", wr_addr[b+1], 159);
        @(negedge clock);
        check("t3_mem160_kept", 32'(mem[160]), 32'd3);
        check("t3_mem159", 32'(mem[159]), 32'd6);

        // engine echoes old colour on odd x
        for (int i = 0; i < 4; i++) preload(810 + i, 7);
        eng_mode = 1'b1;
        eng_col = 3'd2;
        b = wr_addr.size();
        start_rect(10, 5, 3, 0, a0);
        wait_done(a0, 60, lat);
        check("t4_latency", lat, 10);
`ifdef SCREEN_SKIP_UNCHANGED_EN
        check("t4_writes", wr_addr.size() - b, 2);
        check("t4_wr0", wr_addr[b], 810);
        check("t4_wr1", wr_addr[b+1], 812);
`else
        check("t4_writes", wr_addr.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            check("t4_wr_addr", wr_addr[b+i], exp4a[i]);
            check("t4_wr_data", wr_data[b+i], exp4d[i]);
        end
`endif
        @(negedge clock);
        for (int i = 0; i < 4; i++) check("t4_mem", 32'(mem[810+i]), 32'(exp4d[i]));
        eng_mode = 1'b0;

        // start held high: ignored mid-scan, re-accepted after done
        eng_col = 3'd1;
        b = wr_addr.size();
        d0 = done_cnt;
        @(negedge clock);
        screen_x_min = 8'd20;
        screen_y_min = 8'd10;
        screen_x_range = 8'd1;
        screen_y_range = 8'd1;
        screen_start = 1'b1;
        a0 = cyc;
        @(negedge clock);
        wait_done(a0, 60, lat);
        check("t5_first_done", lat, 10);
        @(negedge clock);
        check("t5_reaccept_x", 32'(screen_x), 32'd20);
        screen_start = 1'b0;
        wait_done(a0, 80, lat);
        check("t5_second_done", lat, 20);
        repeat (6) @(negedge clock);
        check("t5_done_count", done_cnt - d0, 2);
        check("t5_writes", wr_addr.size() - b, 8);

        // reset during a WRITE cycle
        eng_col = 3'd4;
        d0 = done_cnt;
        start_rect(5, 2, 3, 3, a0);
        n = 0;
        while (!fb_we && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t6_saw_write", 32'(fb_we), 32'd1);
        reset = 1'b1;
        #1;
        b = wr_addr.size();
        check("t6_we", 32'(fb_we), 32'd0);
        check("t6_wdata", 32'(fb_wdata), 32'd0);
        check("t6_x", 32'(screen_x), 32'd0);
        check("t6_y", 32'(screen_y), 32'd0);
        check("t6_addr", 32'(fb_addr), 32'd0);
        check("t6_done", 32'(screen_done), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_no_writes", wr_addr.size() - b, 0);
        check("t6_idle_x", 32'(screen_x), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_scan.md
Name: screen_scan

Overview:
- Responder side of the screen interface used by the draw opcode engines (clear, triangle).
- On screen_start it latches a rectangle (min plus range) and walks every pixel in raster order.
- For each pixel it reads the old colour from the framebuffer, presents x, y and the old colour to the active draw engine, then writes back the engine's new colour.
- It pulses screen_done when the rectangle is finished. It sits between the draw dispatcher and the framebuffer RAM (synchronous read, 1-cycle latency).

Parameters:
- WIDTH, 8, coordinate and range width.
- COLOUR_WIDTH, 3, pixel colour width.
- SCREEN_SIZE_X, 160, visible columns.
- SCREEN_SIZE_Y, 120, visible rows.
- ADDR_WIDTH, 15, framebuffer address width; must satisfy 2^ADDR_WIDTH >= SCREEN_SIZE_X*SCREEN_SIZE_Y.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- screen_start  in  1  request from draw engine; sampled only in IDLE.
- new_screen_colour  in  COLOUR_WIDTH  colour to write for current pixel; combinational from engine, sampled in WRITE.
- screen_x_min, screen_y_min  in  WIDTH  rectangle origin.
- screen_x_range, screen_y_range  in  WIDTH  rectangle extent, inclusive: x covers min..min+range.
- screen_x, screen_y  out  WIDTH  current pixel.
- old_screen_colour  out  COLOUR_WIDTH  framebuffer contents at current pixel; valid in WRITE.
- screen_done  out  1  one-cycle completion pulse.
- fb_addr  out  ADDR_WIDTH  framebuffer address = screen_y*SCREEN_SIZE_X + screen_x.
- fb_rdata  in  COLOUR_WIDTH  read data, valid one cycle after fb_addr.
- fb_wdata  out  COLOUR_WIDTH  write data.
- fb_we  out  1  write enable.

Behaviour:
- Reset (async, active-high, posedge clock or posedge reset): state IDLE; screen_x, screen_y, fb_addr, fb_wdata, fb_we, screen_done all 0; latched limits 0.
- Outputs are registered except old_screen_colour (= fb_rdata) and fb_we/fb_wdata, which are decoded from state.
- State machine:
  - IDLE: on screen_start, latch x_min, y_min and the end points x_end = x_min + x_range and y_end = y_min + y_range. Compute the end points in WIDTH+1 bits, no wrap. Set screen_x = x_min, screen_y = y_min. Go to READ.
  - READ: drive fb_addr for (screen_x, screen_y). Go to WRITE next cycle.
  - WRITE: old_screen_colour is valid. fb_we = 1 and fb_wdata = new_screen_colour, unless the pixel is clipped. Then advance:
    - if screen_x < x_end: screen_x + 1, go to READ;
    - else if screen_y < y_end: screen_x = x_min, screen_y + 1, go to READ;
    - else go to DONE.
  - DONE: screen_done = 1 for exactly one cycle. Go to IDLE.
- Throughput: 2 cycles per pixel. Latency from start to done = 2*(x_range+1)*(y_range+1) + 2 cycles.
- Clipping: a pixel with x >= SCREEN_SIZE_X or y >= SCREEN_SIZE_Y is still visited, with fb_we forced to 0 in WRITE. This is how an out-of-screen bounding box is handled.
- Ranges of 0 mean a single pixel.
- screen_start while not IDLE is ignored. Rectangle inputs need only be stable on the accepting cycle.
- screen_start asserted in the same cycle as DONE is ignored; it is accepted on the following IDLE cycle if still high.
- Reset mid-scan aborts immediately: no done pulse, no further write.

Optional Feature:
- Macro: SCREEN_SKIP_UNCHANGED_EN.
- Defined: in WRITE, fb_we is additionally suppressed when new_screen_colour == fb_rdata. Visible result is identical; write traffic is reduced.
- Undefined: every in-screen pixel is written.

Decomposition:
- Package screen_pkg holds:
  - state encodings (IDLE, READ, WRITE, DONE);
  - SCREEN_SIZE_X/Y defaults;
  - address-width constant.
- One sub-module, screen_addr_calc: computes fb_addr as y*SCREEN_SIZE_X + x, registered, 1-cycle.

Test Plan:
- Start with min=(2,3), range=(1,1), engine colour=5 -> writes at addresses 482, 483, 642, 643 in that order; screen_done pulses once, exactly 10 cycles after the accept cycle.
- Clear-style start with min=(0,0), range=(159,119), colour=0 -> 19200 writes, the last to address 19199; done after 38402 cycles.
- min=(158,0), range=(3,0) -> x visits 158..161; only 158 and 159 write; done still pulses.
- Engine drives new_screen_colour = old_screen_colour for x odd, with fb preloaded to 7 and range=(3,0) -> writes of 7 at odd x. With SCREEN_SKIP_UNCHANGED_EN, fb_we is low at odd x.
- screen_start held high throughout and pulsed again mid-scan -> the second request is ignored until after the done pulse, then re-accepted.
- Reset asserted during a WRITE cycle -> fb_we drops immediately, no done pulse, state IDLE, all outputs 0.
